// File: rtl/avg8_seq_ctrl_if.sv
// Operand/result bundle for the sequenced eight-input average block.
// The master drives the request and operands; the slave returns status and result.
interface avg8_seq_ctrl_if #(
    parameter int unsigned DATAWIDTH = 16
);
    logic                        start;
    logic signed [DATAWIDTH-1:0] a;
    logic signed [DATAWIDTH-1:0] b;
    logic signed [DATAWIDTH-1:0] c;
    logic signed [DATAWIDTH-1:0] d;
    logic signed [DATAWIDTH-1:0] e;
    logic signed [DATAWIDTH-1:0] f;
    logic signed [DATAWIDTH-1:0] g;
    logic signed [DATAWIDTH-1:0] h;
    logic [7:0]                  sa;
    logic                        busy;
    logic                        done;
    logic signed [DATAWIDTH-1:0] avg;

    modport master (
        output start, a, b, c, d, e, f, g, h, sa,
        input  busy, done, avg
    );

    modport slave (
        input  start, a, b, c, d, e, f, g, h, sa,
        output busy, done, avg
    );
endinterface

// File: rtl/avg8_seq_ctrl.sv
// Eight-input signed average built from one shared adder and one arithmetic
// shifter, sequenced as 7 accumulate steps, 3 shift steps and one output step.
module avg8_seq_ctrl #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned ACCWIDTH  = 32
) (
    input  logic           clk,
    input  logic           rst,
    avg8_seq_ctrl_if.slave bus
);
    localparam int unsigned EXTW = ACCWIDTH - DATAWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SHR  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                      r_state;
    logic signed [DATAWIDTH-1:0] r_op [8];
    logic [7:0]                  r_sa;
    logic signed [ACCWIDTH-1:0]  r_acc;
    logic [2:0]                  r_idx;
    logic [1:0]                  r_sc;
    logic signed [DATAWIDTH-1:0] r_avg;
    logic                        r_done;
    logic                        r_busy;

    logic signed [DATAWIDTH-1:0] w_op_sel;
    logic signed [ACCWIDTH-1:0]  w_op_ext;
    logic signed [ACCWIDTH-1:0]  w_a_ext;
    logic signed [ACCWIDTH-1:0]  w_sum;
    logic signed [ACCWIDTH-1:0]  w_shr;

    // Shared datapath: one operand mux feeding one adder, one shifter on acc.
    assign w_op_sel = r_op[r_idx];
    assign w_op_ext = {{EXTW{w_op_sel[DATAWIDTH-1]}}, w_op_sel};
    assign w_a_ext  = {{EXTW{bus.a[DATAWIDTH-1]}}, bus.a};
    assign w_sum    = r_acc + w_op_ext;
    // Shift amounts at or beyond ACCWIDTH saturate to pure sign fill.
    assign w_shr    = r_acc >>> r_sa;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                r_op[i] <= '0;
            end
            r_sa   <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_sc   <= '0;
            r_avg  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op[0] <= bus.a;
                        r_op[1] <= bus.b;
                        r_op[2] <= bus.c;
                        r_op[3] <= bus.d;
                        r_op[4] <= bus.e;
                        r_op[5] <= bus.f;
                        r_op[6] <= bus.g;
                        r_op[7] <= bus.h;
                        r_sa    <= bus.sa;
                        r_acc   <= w_a_ext;
                        r_idx   <= 3'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        r_sc    <= 2'd0;
                        r_state <= S_SHR;
                    end
                end
                S_SHR: begin
                    r_acc <= w_shr;
                    r_sc  <= r_sc + 2'd1;
                    if (r_sc == 2'd2) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    r_avg   <= r_acc[DATAWIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.avg  = r_avg;
endmodule
